mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative, parametrised multiply/divide unit that produces the HI/LO results for MULT, MULTU, DIV and DIVU.
- Replaces the control FSM's fixed wait counting with a start/busy/done handshake.
- Raises a divide-by-zero flag that the control FSM routes to its ZeroDiv exception state.
- Operand width is generic; signed and unsigned modes are selected per operation.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  1  0 = multiply, 1 = divide.
- sgn  input  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when hi/lo are updated.
- div0  output  1  one-cycle pulse when a divide is requested with b == 0.
- hi  output  WIDTH  product upper half, or remainder.
- lo  output  WIDTH  product lower half, or quotient.

Behaviour:
- Reset values: busy=0, done=0, div0=0, hi=0, lo=0, state=IDLE, counter=0.
- Reset takes priority over every other input in every state.
- Reset mid-operation aborts the operation: no done is issued, and hi/lo are cleared.

States:
- IDLE: waits for start. On the edge where start=1:
  - Latch op, sgn, a and b.
  - op=1 and b==0: go to ERR.
  - op=0: go to MUL.
  - op=1 and b!=0: go to DIV.
  - busy=1 from the cycle after that edge.
- MUL: exactly WIDTH iteration cycles.
  - sgn=1: radix-2 Booth recoding on a 2*WIDTH+1-bit accumulator.
  - sgn=0: shift-add on zero-extended operands.
- DIV: exactly WIDTH cycles of restoring division on the operand magnitudes.
  - Operands are converted to magnitudes at latch time when sgn=1.
- FIX: one cycle.
  - Signed divide: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - hi/lo are written on this edge.
- DONE: one cycle with done=1, busy=0, then IDLE.
- ERR: one cycle with div0=1 and done=1, then IDLE. hi/lo keep their previous values.

Latency:
- start sampled at edge E0.
- done is high during the cycle following edge E0+WIDTH+2, i.e. the cycle after the WIDTH iteration edges plus the FIX edge.
- Divide-by-zero: div0 and done are high in the cycle after E0+1.

Outputs and handshake:
- hi/lo hold their values until the next successful completion.
- start while busy=1 (states MUL, DIV, FIX) is ignored; there is no queueing.
- start during the DONE cycle is also ignored; the next start is accepted in IDLE.
- Operand inputs may change after E0; only the latched copies are used.

Arithmetic:
- All results are WIDTH-bit two's complement with wrap-around.
- Signed INT_MIN / -1: lo = INT_MIN, hi = 0, no exception.
- Signed INT_MIN * INT_MIN: hi = 0x40000000, lo = 0 (WIDTH=32).
- Multiply never overflows; the full 2*WIDTH-bit product is returned.

Test Plan:
1. MULT sgn=1, a=7, b=0xFFFFFFFD (-3) -> done in the cycle after E0+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 34 cycles.
2. DIV sgn=1, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Same operands with sgn=0 -> lo=0x7FFFFFFC, hi=1.
3. DIV sgn=1, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0 stays 0.
4. Preload hi/lo via MULTU 3*5 (lo=15), then DIV with b=0 -> div0=1 and done=1 in the cycle after E0+1, busy never asserts, hi=0 and lo=15 unchanged.
5. MULTU 0xFFFFFFFF*0xFFFFFFFF with a second start (different operands) pulsed at E0+5 -> second start ignored; hi=0xFFFFFFFE, lo=0x00000001; exactly one done pulse.
6. Start DIV, assert reset at E0+10 -> following cycle busy=0, done=0, hi=lo=0; no done for the aborted operation; a new start is accepted normally afterwards.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control FSM and the multiply/divide unit.
// The control side drives the operation request; the unit returns status and results.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, sgn, a, b,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, sgn, a, b,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: Booth or shift-add multiply, restoring divide,
// start/busy/done handshake and a divide-by-zero pulse.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL, S_DIV, S_FIX, S_DONE, S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_busy;
  logic               w_done;
  logic               w_div0;

  logic               r_op;
  logic               r_sgn;
  logic               r_divz;
  logic               r_negQ;
  logic               r_negR;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH:0]   r_acc;
  logic               r_qm1;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH:0]     w_mulM;
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH:0]   w_mulAcc;
  logic [WIDTH:0]     w_divShift;
  logic [WIDTH:0]     w_divTrial;
  logic [2*WIDTH:0]   w_divAcc;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // The LOAD cycle decides between ERR and the iteration states; it only counts as busy for a real operation
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    w_div0 = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_LOAD;
      S_LOAD: begin
        w_busy = !r_divz;
        if (r_divz)    w_next = S_ERR;
        else if (r_op) w_next = S_DIV;
        else           w_next = S_MUL;
      end
      S_MUL, S_DIV: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_FIX;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        w_done = 1'b1;
        w_div0 = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Upper accumulator half carries one guard bit so -INT_MIN and unsigned carries stay exact
  always_comb begin
    w_mulM   = r_sgn ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
    w_mulSum = r_acc[2*WIDTH:WIDTH];
    if (r_sgn) begin
      case ({r_acc[0], r_qm1})
        2'b01:   w_mulSum = r_acc[2*WIDTH:WIDTH] + w_mulM;
        2'b10:   w_mulSum = r_acc[2*WIDTH:WIDTH] - w_mulM;
        default: w_mulSum = r_acc[2*WIDTH:WIDTH];
      endcase
    end else if (r_acc[0]) begin
      w_mulSum = r_acc[2*WIDTH:WIDTH] + w_mulM;
    end
    w_mulAcc = {r_sgn & w_mulSum[WIDTH], w_mulSum, r_acc[WIDTH-1:1]};

    w_divShift = r_acc[2*WIDTH-1:WIDTH-1];
    w_divTrial = w_divShift - {1'b0, r_b};
    if (w_divTrial[WIDTH]) w_divAcc = {w_divShift, r_acc[WIDTH-2:0], 1'b0};
    else                   w_divAcc = {w_divTrial, r_acc[WIDTH-2:0], 1'b1};

    w_quot = r_acc[WIDTH-1:0];
    w_rem  = r_acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= 1'b0;
      r_sgn  <= 1'b0;
      r_divz <= 1'b0;
      r_negQ <= 1'b0;
      r_negR <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_qm1  <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_op   <= bus.op;
          r_sgn  <= bus.sgn;
          r_divz <= bus.op && (bus.b == '0);
          r_negQ <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          r_negR <= bus.sgn & bus.a[WIDTH-1];
          r_a    <= (bus.op && bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
          r_b    <= (bus.op && bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        end
        S_LOAD: begin
          r_acc <= r_op ? {{(WIDTH+1){1'b0}}, r_a} : {{(WIDTH+1){1'b0}}, r_b};
          r_qm1 <= 1'b0;
          r_cnt <= '0;
        end
        S_MUL: begin
          r_acc <= w_mulAcc;
          r_qm1 <= r_acc[0];
          r_cnt <= r_cnt + 1'b1;
        end
        S_DIV: begin
          r_acc <= w_divAcc;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (r_op) begin
            r_lo <= r_negQ ? -w_quot : w_quot;
            r_hi <= r_negR ? -w_rem : w_rem;
          end else begin
            r_lo <= w_quot;
            r_hi <= w_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.div0 = w_div0;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized bench for mult_div_unit; results are compared against
// a plain-arithmetic model of MULT/MULTU/DIV/DIVU and the handshake timing.
module tb_mult_div_unit;

  localparam int WIDTH     = 32;
  localparam int OP_CYCLES = 60;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int          gDoneIdx, gBusyCnt, gDoneCnt, gDiv0Cnt;
  logic [31:0] modelHi, modelLo;

  mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions
  function automatic void refModel(input logic op, input logic sgn, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb;
    logic [63:0] p, q, r;
    if (!op) begin
      if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else     p = {32'b0, a} * {32'b0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 64'(sa / sb);
      r  = 64'(sa % sb);
      hi = r[31:0];
      lo = q[31:0];
    end else begin
      hi = a % b;
      lo = a / b;
    end
  endfunction

  // Issues one request, scrambles the operand inputs after the accepting edge and watches the handshake
  task automatic applyStimulus(input logic op, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input int extraStartAt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.sgn   = sgn;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.sgn   = 1'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    gDoneIdx = -1;
    gBusyCnt = 0;
    gDoneCnt = 0;
    gDiv0Cnt = 0;
    for (int k = 1; k <= OP_CYCLES; k++) begin
      @(negedge clk);
      if (bus.busy) gBusyCnt++;
      if (bus.div0) gDiv0Cnt++;
      if (bus.done) begin
        gDoneCnt++;
        if (gDoneIdx < 0) gDoneIdx = k;
      end
      if (k == extraStartAt) begin
        bus.start = 1'b1;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic checkRun(input string tag, input logic isDiv0, input logic [31:0] expHi,
                          input logic [31:0] expLo);
    checkOutput({tag, "_doneCycle"}, 64'(gDoneIdx), isDiv0 ? 64'd2 : 64'(WIDTH + 3));
    checkOutput({tag, "_busyCycles"}, 64'(gBusyCnt), isDiv0 ? 64'd0 : 64'(WIDTH + 2));
    checkOutput({tag, "_donePulses"}, 64'(gDoneCnt), 64'd1);
    checkOutput({tag, "_div0Pulses"}, 64'(gDiv0Cnt), isDiv0 ? 64'd1 : 64'd0);
    checkOutput({tag, "_hi"}, 64'(bus.hi), 64'(expHi));
    checkOutput({tag, "_lo"}, 64'(bus.lo), 64'(expLo));
  endtask

  initial begin
    logic        rOp, rSgn, rZero;
    logic [31:0] rA, rB, eHi, eLo;
    int          lateDone;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_div0", 64'(bus.div0), 64'd0);
    checkOutput("reset_hi", 64'(bus.hi), 64'd0);
    checkOutput("reset_lo", 64'(bus.lo), 64'd0);

    applyStimulus(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 0);
    checkRun("mult_7_m3", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    checkRun("div_m7_2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    checkRun("divu_m7_2", 1'b0, 32'h0000_0001, 32'h7FFF_FFFC);

    applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    checkRun("div_intmin_m1", 1'b0, 32'h0000_0000, 32'h8000_0000);

    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
    checkRun("mult_intmin_sq", 1'b0, 32'h4000_0000, 32'h0000_0000);

    applyStimulus(1'b0, 1'b0, 32'd3, 32'd5, 0);
    checkRun("multu_3_5", 1'b0, 32'h0000_0000, 32'd15);

    applyStimulus(1'b1, 1'b1, 32'd1234, 32'd0, 0);
    checkRun("div_by_zero", 1'b1, 32'h0000_0000, 32'd15);

    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    checkRun("multu_max_restart", 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);

    // Abort a divide with reset partway through the iterations
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.sgn   = 1'b0;
    bus.a     = 32'd1000;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_done", 64'(bus.done), 64'd0);
    checkOutput("abort_hi", 64'(bus.hi), 64'd0);
    checkOutput("abort_lo", 64'(bus.lo), 64'd0);
    reset    = 1'b0;
    lateDone = 0;
    for (int k = 0; k < OP_CYCLES; k++) begin
      @(negedge clk);
      if (bus.done) lateDone++;
    end
    checkOutput("abort_no_done", 64'(lateDone), 64'd0);

    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd7, 0);
    checkRun("after_abort_divu", 1'b0, 32'd6, 32'd142);
    modelHi = 32'd6;
    modelLo = 32'd142;

    for (int n = 0; n < 16; n++) begin
      rOp   = 1'($urandom);
      rSgn  = 1'($urandom);
      rA    = $urandom;
      rB    = $urandom;
      if (n % 4 == 1) rB = 32'($urandom_range(0, 20)) - 32'd10;
      if (n % 4 == 2) rA = {1'b1, 31'($urandom_range(0, 3))};
      rZero = rOp && (rB == 32'd0);
      if (rZero) begin
        eHi = modelHi;
        eLo = modelLo;
      end else begin
        refModel(rOp, rSgn, rA, rB, eHi, eLo);
        modelHi = eHi;
        modelLo = eLo;
      end
      applyStimulus(rOp, rSgn, rA, rB, 0);
      checkRun($sformatf("rand%0d_op%0d_s%0d", n, rOp, rSgn), rZero, eHi, eLo);
    end

    applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, 0);
    checkRun("divu_by_zero_hold", 1'b1, modelHi, modelLo);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
